// File: rtl/fpu_class_fflags_if.sv
// fpu_class_fflags_if
// Bundles the streaming handshake, operand/result buses and the CSR-side
// accumulator access of the FP classifier.
//   master : producer/consumer side (drives valid_in, operands, ready_out, clear_acc)
//   slave  : the classifier (drives ready_in, results, fflags_acc)
interface fpu_class_fflags_if #(
  parameter int NUM_LANES = 4,
  parameter int EXP_BITS  = 8,
  parameter int MAN_BITS  = 23,
  parameter int TAG_WIDTH = 8
);
  localparam int FLEN = 1 + EXP_BITS + MAN_BITS;

  logic                      valid_in;
  logic                      ready_in;
  logic [TAG_WIDTH-1:0]      tag_in;
  logic [NUM_LANES*FLEN-1:0] data_in;
  logic [NUM_LANES-1:0]      lane_mask_in;
  logic [NUM_LANES*5-1:0]    fflags_in;
  logic                      snan_nv_in;
  logic                      valid_out;
  logic                      ready_out;
  logic [TAG_WIDTH-1:0]      tag_out;
  logic [NUM_LANES*10-1:0]   class_out;
  logic [4:0]                fflags_out;
  logic                      clear_acc;
  logic [4:0]                fflags_acc;

  modport master (
    output valid_in, tag_in, data_in, lane_mask_in, fflags_in, snan_nv_in,
           ready_out, clear_acc,
    input  ready_in, valid_out, tag_out, class_out, fflags_out, fflags_acc
  );

  modport slave (
    input  valid_in, tag_in, data_in, lane_mask_in, fflags_in, snan_nv_in,
           ready_out, clear_acc,
    output ready_in, valid_out, tag_out, class_out, fflags_out, fflags_acc
  );
endinterface

// File: rtl/fpu_class_fflags.sv
// fpu_class_fflags
// Two-stage elastic pipeline that classifies up to NUM_LANES floating-point
// operands (RISC-V FCLASS one-hot per lane), ORs the exception flags of the
// active lanes (optionally promoting sNaN inputs to NV) and keeps a sticky
// 5-bit flag accumulator for CSR access.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : fpu_class_fflags_if.slave (input/output handshakes, operands,
//             class/flag results, clear_acc / fflags_acc)
module fpu_class_fflags #(
  parameter int NUM_LANES = 4,
  parameter int EXP_BITS  = 8,
  parameter int MAN_BITS  = 23,
  parameter int TAG_WIDTH = 8
) (
  input logic                clk,
  input logic                reset_n,
  fpu_class_fflags_if.slave  bus
);
  localparam int FLEN = 1 + EXP_BITS + MAN_BITS;

  // Raw field predicates of the incoming operands
  logic [NUM_LANES-1:0] in_sign, in_exp_zero, in_exp_ones, in_man_zero, in_quiet;
  logic [4:0]           in_flags;

  // Stage 1 state
  logic                 s1_valid;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 s1_snan_nv;
  logic [NUM_LANES-1:0] s1_mask;
  logic [4:0]           s1_flags;
  logic [NUM_LANES-1:0] s1_sign, s1_exp_zero, s1_exp_ones, s1_man_zero, s1_quiet;

  // Stage 2 state
  logic                    s2_valid;
  logic [TAG_WIDTH-1:0]    s2_tag;
  logic [NUM_LANES*10-1:0] s2_class;
  logic [4:0]              s2_flags;
  logic [4:0]              acc;

  // Stage 2 combinational results
  logic [NUM_LANES*10-1:0] cls_next;
  logic [NUM_LANES-1:0]    snan_active;
  logic [4:0]              flags_next;

  logic s1_adv, s2_adv, fire;

  assign s2_adv = !s2_valid || bus.ready_out;
  assign s1_adv = !s1_valid || s2_adv;
  assign fire   = s2_valid && bus.ready_out;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_dec
    logic [FLEN-1:0] lane;
    assign lane           = bus.data_in[i*FLEN +: FLEN];
    assign in_sign[i]     = lane[FLEN-1];
    assign in_exp_zero[i] = (lane[FLEN-2 -: EXP_BITS] == '0);
    assign in_exp_ones[i] = &lane[FLEN-2 -: EXP_BITS];
    assign in_man_zero[i] = (lane[MAN_BITS-1:0] == '0);
    assign in_quiet[i]    = lane[MAN_BITS-1];
  end

  // Flags of inactive lanes are ignored entirely
  always_comb begin
    in_flags = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.lane_mask_in[i]) in_flags = in_flags | bus.fflags_in[i*5 +: 5];
    end
  end

  // Stage 1 loads whenever it can advance; a bubble simply loads s1_valid=0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_tag      <= '0;
      s1_snan_nv  <= 1'b0;
      s1_mask     <= '0;
      s1_flags    <= '0;
      s1_sign     <= '0;
      s1_exp_zero <= '0;
      s1_exp_ones <= '0;
      s1_man_zero <= '0;
      s1_quiet    <= '0;
    end else if (s1_adv) begin
      s1_valid    <= bus.valid_in;
      s1_tag      <= bus.tag_in;
      s1_snan_nv  <= bus.snan_nv_in;
      s1_mask     <= bus.lane_mask_in;
      s1_flags    <= in_flags;
      s1_sign     <= in_sign;
      s1_exp_zero <= in_exp_zero;
      s1_exp_ones <= in_exp_ones;
      s1_man_zero <= in_man_zero;
      s1_quiet    <= in_quiet;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_cls
    logic nan, snan, qnan, inf, zero, sub, norm, s;
    assign s    = s1_sign[i];
    assign nan  = s1_exp_ones[i] && !s1_man_zero[i];
    assign snan = nan && !s1_quiet[i];
    assign qnan = nan && s1_quiet[i];
    assign inf  = s1_exp_ones[i] && s1_man_zero[i];
    assign zero = s1_exp_zero[i] && s1_man_zero[i];
    assign sub  = s1_exp_zero[i] && !s1_man_zero[i];
    assign norm = !s1_exp_zero[i] && !s1_exp_ones[i];
    // Bit 9 down to bit 0: qNaN, sNaN, +inf, +norm, +sub, +0, -0, -sub, -norm, -inf
    assign cls_next[i*10 +: 10] = s1_mask[i] ?
      {qnan, snan, !s && inf, !s && norm, !s && sub, !s && zero,
       s && zero, s && sub, s && norm, s && inf} : 10'd0;
    assign snan_active[i] = s1_mask[i] && snan;
  end

  assign flags_next = s1_flags | {s1_snan_nv && (|snan_active), 4'b0000};

  // Stage 2 holds everything while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      s2_class <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s2_class <= cls_next;
      s2_flags <= flags_next;
    end
  end

  // A clear coinciding with a transfer keeps that transfer's flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (bus.clear_acc) begin
      acc <= fire ? s2_flags : 5'd0;
    end else if (fire) begin
      acc <= acc | s2_flags;
    end
  end

  assign bus.ready_in   = s1_adv;
  assign bus.valid_out  = s2_valid;
  assign bus.tag_out    = s2_tag;
  assign bus.class_out  = s2_class;
  assign bus.fflags_out = s2_flags;
  assign bus.fflags_acc = acc;
endmodule

// File: tb/tb_fpu_class_fflags.sv
// tb_fpu_class_fflags
// Directed plus light random stimulus for fpu_class_fflags. Expected results
// are predicted at input transfer, queued, and compared by a negedge monitor
// when the DUT transfers a result; the monitor also tracks the accumulator.
module tb_fpu_class_fflags;
  localparam int NL   = 4;
  localparam int EB   = 8;
  localparam int MB   = 23;
  localparam int TW   = 8;
  localparam int FLEN = 1 + EB + MB;

  typedef struct {
    logic [TW-1:0]    tag;
    logic [NL*10-1:0] cls;
    logic [4:0]       flg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [4:0] acc_model = 5'd0;
  logic [4:0] mon_flags;
  logic       mon_fire;

  always #5 clk = ~clk;

  fpu_class_fflags_if #(.NUM_LANES(NL), .EXP_BITS(EB), .MAN_BITS(MB), .TAG_WIDTH(TW)) bus ();

  fpu_class_fflags #(.NUM_LANES(NL), .EXP_BITS(EB), .MAN_BITS(MB), .TAG_WIDTH(TW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  function automatic logic [9:0] classify(input logic [FLEN-1:0] v);
    logic [EB-1:0] ex;
    logic [MB-1:0] man;
    logic          s;
    ex  = v[FLEN-2 -: EB];
    man = v[MB-1:0];
    s   = v[FLEN-1];
    if (ex == {EB{1'b1}}) begin
      if (man == '0) return s ? 10'h001 : 10'h080;
      return man[MB-1] ? 10'h200 : 10'h100;
    end
    if (ex == '0) begin
      if (man == '0) return s ? 10'h008 : 10'h010;
      return s ? 10'h004 : 10'h020;
    end
    return s ? 10'h002 : 10'h040;
  endfunction

  function automatic exp_t predict(input logic [TW-1:0] tag, input logic [NL*FLEN-1:0] data,
                                   input logic [NL-1:0] mask, input logic [NL*5-1:0] flags,
                                   input logic snan);
    exp_t       e;
    logic [9:0] c;
    e.tag = tag;
    e.cls = '0;
    e.flg = '0;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        c = classify(data[i*FLEN +: FLEN]);
        e.cls[i*10 +: 10] = c;
        e.flg = e.flg | flags[i*5 +: 5];
        if (snan && c == 10'h100) e.flg[4] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [FLEN-1:0] randLane();
    logic [FLEN-1:0] v;
    v = FLEN'($urandom);
    case ($urandom_range(0, 5))
      0: v[FLEN-2 -: EB] = '1;
      1: v[FLEN-2 -: EB] = '0;
      2: v[MB-1:0] = '0;
      3: begin v[FLEN-2 -: EB] = '1; v[MB-1:0] = MB'(1); end
      default: ;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic syncUp();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction (call at posedge+1), waits bounded for acceptance
  task automatic applyStimulus(input logic [TW-1:0] tag, input logic [NL*FLEN-1:0] data,
                               input logic [NL-1:0] mask, input logic [NL*5-1:0] flags,
                               input logic snan);
    int n;
    n = 0;
    bus.valid_in     = 1'b1;
    bus.tag_in       = tag;
    bus.data_in      = data;
    bus.lane_mask_in = mask;
    bus.fflags_in    = flags;
    bus.snan_nv_in   = snan;
    @(negedge clk);
    while (bus.ready_in !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept", 64'(bus.ready_in), 64'd1);
    if (bus.ready_in === 1'b1) sb.push_back(predict(tag, data, mask, flags, snan));
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
    syncUp();
  endtask

  // Scoreboard and accumulator model, evaluated once per cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      acc_model = 5'd0;
    end else begin
      checkOutput("fflags_acc", 64'(bus.fflags_acc), 64'(acc_model));
      mon_fire  = bus.valid_out && bus.ready_out;
      mon_flags = 5'd0;
      if (mon_fire) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_output observed tag=0x%0h expected no output", bus.tag_out);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checkOutput("tag_out", 64'(bus.tag_out), 64'(mon_e.tag));
          checkOutput("class_out", 64'(bus.class_out), 64'(mon_e.cls));
          checkOutput("fflags_out", 64'(bus.fflags_out), 64'(mon_e.flg));
          mon_flags = mon_e.flg;
        end
      end
      if (bus.clear_acc) acc_model = mon_fire ? mon_flags : 5'd0;
      else if (mon_fire) acc_model = acc_model | mon_flags;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] SNAN = 32'h7F800001;

  initial begin
    bus.valid_in = 1'b0;
    bus.tag_in = '0;
    bus.data_in = '0;
    bus.lane_mask_in = '0;
    bus.fflags_in = '0;
    bus.snan_nv_in = 1'b0;
    bus.ready_out = 1'b1;
    bus.clear_acc = 1'b0;

    #2;
    checkOutput("rst_valid_out", 64'(bus.valid_out), 64'd0);
    checkOutput("rst_tag_out", 64'(bus.tag_out), 64'd0);
    checkOutput("rst_class_out", 64'(bus.class_out), 64'd0);
    checkOutput("rst_fflags_out", 64'(bus.fflags_out), 64'd0);
    checkOutput("rst_fflags_acc", 64'(bus.fflags_acc), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready_in", 64'(bus.ready_in), 64'd1);
    syncUp();

    // All classes, latency 2
    applyStimulus(8'h10, {32'h80000000, 32'h80000001, 32'hBF800000, 32'hFF800000}, 4'hF, '0, 1'b0);
    @(negedge clk);
    checkOutput("latency_early", 64'(bus.valid_out), 64'd0);
    @(negedge clk);
    checkOutput("latency_valid", 64'(bus.valid_out), 64'd1);
    syncUp();
    applyStimulus(8'h11, {32'h7F800000, ONE, 32'h00000001, 32'h00000000}, 4'hF, '0, 1'b0);
    applyStimulus(8'h12, {32'hFFC00000, 32'h00400000, 32'h7FC00000, SNAN}, 4'hF, '0, 1'b0);
    drain();

    // sNaN promotion on/off
    applyStimulus(8'h20, {ONE, ONE, ONE, SNAN}, 4'hF, '0, 1'b1);
    applyStimulus(8'h21, {ONE, ONE, ONE, SNAN}, 4'hF, '0, 1'b0);
    // Masking, with an sNaN on an inactive lane
    applyStimulus(8'h22, {ONE, ONE, SNAN, ONE}, 4'b0101, {5'h08, 5'h04, 5'h02, 5'h01}, 1'b1);
    // All-zero mask still flows
    applyStimulus(8'h23, {SNAN, SNAN, SNAN, SNAN}, 4'b0000, {NL{5'h1F}}, 1'b1);
    drain();

    // Back-pressure
    bus.ready_out = 1'b0;
    applyStimulus(8'h01, {ONE, ONE, ONE, ONE}, 4'hF, '0, 1'b0);
    applyStimulus(8'h02, {ONE, ONE, ONE, 32'h00000000}, 4'hF, '0, 1'b0);
    bus.valid_in = 1'b1;
    bus.tag_in = 8'h03;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_ready_in", 64'(bus.ready_in), 64'd0);
      checkOutput("bp_valid_hold", 64'(bus.valid_out), 64'd1);
      checkOutput("bp_tag_hold", 64'(bus.tag_out), 64'h01);
    end
    syncUp();
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", 64'(bus.ready_in), 64'd1);
    syncUp();
    applyStimulus(8'h03, {ONE, ONE, 32'h80000000, ONE}, 4'hF, '0, 1'b0);
    applyStimulus(8'h04, {ONE, 32'h7F800000, ONE, ONE}, 4'hF, '0, 1'b0);
    drain();

    // Accumulator
    bus.clear_acc = 1'b1;
    syncUp();
    bus.clear_acc = 1'b0;
    @(negedge clk);
    checkOutput("acc_init_clear", 64'(bus.fflags_acc), 64'h00);
    syncUp();
    applyStimulus(8'h30, {ONE, ONE, ONE, ONE}, 4'hF, {5'h00, 5'h00, 5'h00, 5'h01}, 1'b0);
    applyStimulus(8'h31, {ONE, ONE, ONE, ONE}, 4'hF, {5'h00, 5'h00, 5'h08, 5'h00}, 1'b0);
    drain();
    @(negedge clk);
    checkOutput("acc_or", 64'(bus.fflags_acc), 64'h09);
    syncUp();
    applyStimulus(8'h32, {ONE, ONE, ONE, ONE}, 4'hF, {5'h00, 5'h04, 5'h00, 5'h00}, 1'b0);
    syncUp();
    bus.clear_acc = 1'b1;
    syncUp();
    bus.clear_acc = 1'b0;
    @(negedge clk);
    checkOutput("acc_clear_fire", 64'(bus.fflags_acc), 64'h04);
    syncUp();

    // Reset with both stages full
    bus.ready_out = 1'b0;
    applyStimulus(8'h40, {ONE, ONE, ONE, ONE}, 4'hF, {NL{5'h01}}, 1'b0);
    applyStimulus(8'h41, {ONE, ONE, ONE, ONE}, 4'hF, {NL{5'h02}}, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid_out", 64'(bus.valid_out), 64'd0);
    checkOutput("rst_mid_fflags_acc", 64'(bus.fflags_acc), 64'd0);
    bus.ready_out = 1'b1;
    syncUp();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_rel_ready_in", 64'(bus.ready_in), 64'd1);
    checkOutput("rst_rel_valid_out", 64'(bus.valid_out), 64'd0);
    syncUp();

    // Clear alone
    applyStimulus(8'h50, {ONE, ONE, ONE, ONE}, 4'hF, {5'h00, 5'h00, 5'h00, 5'h02}, 1'b0);
    drain();
    @(negedge clk);
    checkOutput("acc_pre_clear", 64'(bus.fflags_acc), 64'h02);
    syncUp();
    bus.clear_acc = 1'b1;
    syncUp();
    bus.clear_acc = 1'b0;
    @(negedge clk);
    checkOutput("acc_clear_only", 64'(bus.fflags_acc), 64'h00);
    syncUp();

    // Random operands, masks and flags
    for (int k = 0; k < 24; k++) begin
      applyStimulus(8'(8'h80 + k), {randLane(), randLane(), randLane(), randLane()},
                    NL'($urandom), (NL*5)'($urandom), 1'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
